uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial UART receiver. It is the downstream partner of the team's Tx block and shares its frame format: start bit, Data_Width data bits LSB first, optional parity bit, one stop bit. Each bit lasts OverSampling clk cycles, and the same clk is the oversampling tick (no separate baud enable). The block synchronises the line, recovers frames by sampling at bit centres, checks parity and framing, and presents each byte through a one-entry valid/ready output register.

Parameters:
Data_Width, 8, data bits per frame
OverSampling, 16, clk cycles per bit; even, >= 4
Sync_Stages, 2, synchroniser flops on rx

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset
rx  in  1  asynchronous serial line; idle high
parity_en  in  1  1 = frame carries a parity bit
parity_type  in  1  0 = expected parity bit is ~^data; 1 = ^data (same encoding as Tx)
rx_data  out  Data_Width  received word
rx_valid  out  1  rx_data, parity_err and frame_err are valid
rx_ready  in  1  consumer accepts the word when rx_valid & rx_ready
parity_err  out  1  parity mismatch for the held word
frame_err  out  1  stop bit sampled low for the held word
overrun_err  out  1  sticky; a frame was dropped because the holding register was full
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset == 0 at a clk edge):
  - FSM goes to IDLE; all counters clear.
  - Synchroniser flops and previous-sample register load 1.
  - rx_data = 0; rx_valid, parity_err, frame_err, overrun_err and busy all = 0.
  - Reset mid-frame abandons the frame with no output.
- Synchroniser: rx passes through Sync_Stages flops to give rx_s; rx_prev holds rx_s delayed one cycle.
- Start detect: only in IDLE, on rx_prev == 1 && rx_s == 0. A line stuck low does not retrigger.
- START:
  - Counter runs 0..OverSampling/2-1.
  - At the final count, sample rx_s. If 0, zero the counter and go to DATA. If 1, treat as a glitch and return to IDLE with no output and no flags.
  - parity_en and parity_type are latched here; changing them mid-frame has no effect.
- DATA:
  - Counter runs 0..OverSampling-1; rx_s is sampled at OverSampling-1, which is the bit centre.
  - Each sample shifts in at the MSB of the shift register and the register shifts right. After Data_Width samples, bit 0 holds the first bit received.
  - bit_index counts 0..Data_Width-1. After the last bit, go to PARITY if parity_en is latched high, otherwise STOP.
- PARITY: sample at count OverSampling-1. parity_fail = (sample != expected), where expected is computed over the assembled data word per the latched parity_type.
- STOP: sample at count OverSampling-1; frame_fail = (sample == 0). Then go to IDLE immediately (mid stop bit) so the next start edge can be caught.
  - After a framing error, the line must return high before a new start is recognised; the edge rule above enforces this.
- Output register, updated on the clk edge that completes the stop sample:
  - If rx_valid == 0, or rx_ready == 1 in the same cycle: load rx_data, parity_err and frame_err; set rx_valid = 1.
  - Otherwise: drop the new frame; held data is unchanged; overrun_err = 1.
  - On a handshake with no new load: rx_valid = 0 and overrun_err clears.
  - A new load coincident with a handshake keeps overrun_err unchanged.
- Latency: rx_valid rises 1 clk after the stop-bit centre sample. Approximately Sync_Stages + OverSampling/2 + (Data_Width + 1 + parity_en)*OverSampling + 1 cycles after the falling edge of rx.
- Back-to-back frames from Tx: the gap is at least OverSampling/2 cycles of stop bit, which is enough for edge detect.

Decomposition:
- uart_pkg: rx_state_t enum {IDLE, START, DATA, PARITY, STOP}, default Data_Width/OverSampling constants, and a function parity_bit(data, parity_type) shared with Tx.
- Sub-module uart_rx_sync: parameterised synchroniser plus falling-edge detect, outputs rx_s and fall.

Test Plan:
- 0xA5, parity_en=0, rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0xA5, parity_err=0, frame_err=0.
- 0x3C, parity_en=1, parity_type=0, parity bit 1 (=~^0x3C) -> rx_data=0x3C, parity_err=0. Same frame with parity bit 0 -> parity_err=1.
- 0x81 with stop bit forced 0 -> frame_err=1, rx_data=0x81. Line held low afterwards produces no further frames until rx returns high.
- rx low pulse of 4 cycles in IDLE -> no rx_valid, busy returns to 0 after OverSampling/2 + Sync_Stages cycles.
- rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, overrun_err=1. Assert rx_ready for 1 cycle -> rx_valid=0, overrun_err=0.
- reset low for 1 cycle mid-DATA of 0x55 -> no output, busy=0. A following 0x66 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame
// constants and the parity helper used by both Tx and Rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned OVER_SAMPLING = 16;

    // Parity bit for a word: type 0 gives ~^data, type 1 gives ^data.
    // Callers zero-extend narrower words; the padding does not change parity.
    function automatic logic parity_bit(input logic [31:0] data,
                                        input logic        parity_type);
        return parity_type ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the serial line plus a registered
// copy of the synchronised level used for falling-edge detection.
module uart_rx_sync #(
    parameter int Sync_Stages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [Sync_Stages-1:0] sync_q;
    logic [Sync_Stages-1:0] sync_d;
    logic [Sync_Stages:0]   chain;
    logic                   prev_q;

    assign chain  = {sync_q, rx};
    assign sync_d = chain[Sync_Stages-1:0];
    assign rx_s   = sync_q[Sync_Stages-1];
    assign fall   = prev_q & ~rx_s;

    // Shift the line through the flop chain; idle-high after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= rx_s;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-samples start/data/parity/stop bits and hands
// each word to the consumer through a one-entry valid/ready register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int Data_Width   = DATA_WIDTH,
    parameter int OverSampling = OVER_SAMPLING,
    parameter int Sync_Stages  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  parity_en,
    input  logic                  parity_type,
    output logic [Data_Width-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int CW   = $clog2(OverSampling);
    localparam int BW   = (Data_Width > 1) ? $clog2(Data_Width) : 1;
    localparam int HALF = OverSampling / 2;

    logic rx_s;
    logic fall;

    rx_state_t state_q, state_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [Data_Width-1:0] shift_q, shift_d;
    logic [Data_Width:0]   shift_cat;
    logic                  pen_q, pen_d;
    logic                  ptype_q, ptype_d;
    logic                  pfail_q, pfail_d;

    logic [Data_Width-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;

    logic last_half;
    logic last_full;
    logic last_bit;
    logic done;
    logic load;
    logic hs;

    uart_rx_sync #(
        .Sync_Stages(Sync_Stages)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    assign last_half = (cnt_q == CW'(HALF - 1));
    assign last_full = (cnt_q == CW'(OverSampling - 1));
    assign last_bit  = (bit_q == BW'(Data_Width - 1));
    assign done      = (state_q == STOP) && last_full;
    assign load      = done && (!valid_q || rx_ready);
    assign hs        = valid_q && rx_ready;
    assign shift_cat = {rx_s, shift_q};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a high level at the start-bit centre is a glitch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fall) state_d = START;
            end
            START: begin
                if (last_half) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (last_full && last_bit) state_d = pen_q ? PARITY : STOP;
            end
            PARITY: begin
                if (last_full) state_d = STOP;
            end
            STOP: begin
                if (last_full) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Bit timing, data assembly and parity bookkeeping.
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pen_d   = pen_q;
        ptype_d = ptype_q;
        pfail_d = pfail_q;
        if (state_q == IDLE || state_d != state_q ||
            (state_q == DATA && last_full)) begin
            cnt_d = '0;
        end
        if (state_q == IDLE) begin
            bit_d   = '0;
            pfail_d = 1'b0;
        end
        if (state_q == START && last_half) begin
            pen_d   = parity_en;
            ptype_d = parity_type;
        end
        if (state_q == DATA && last_full) begin
            shift_d = shift_cat[Data_Width:1];
            bit_d   = last_bit ? '0 : bit_q + BW'(1);
        end
        if (state_q == PARITY && last_full) begin
            pfail_d = (rx_s != parity_bit(32'(shift_q), ptype_q));
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pen_q   <= 1'b0;
            ptype_q <= 1'b0;
            pfail_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pen_q   <= pen_d;
            ptype_q <= ptype_d;
            pfail_q <= pfail_d;
        end
    end

    // Holding register: load when free or draining, else drop and flag.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (load) begin
            data_d  = shift_q;
            perr_d  = pfail_q;
            ferr_d  = ~rx_s;
            valid_d = 1'b1;
        end else if (done) begin
            ovr_d = 1'b1;
        end else if (hs) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios followed by
// random frames checked against a frame-level reference model.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          parity_en;
    logic          parity_type;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          parity_err;
    logic          frame_err;
    logic          overrun_err;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW+1:0] got_q[$];

    uart_rx #(
        .Data_Width  (DW),
        .OverSampling(OS),
        .Sync_Stages (SS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_type(parity_type),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Record every accepted word as {data, parity_err, frame_err}.
    always @(negedge clk) begin
        if (reset && rx_valid && rx_ready)
            got_q.push_back({rx_data, parity_err, frame_err});
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Parity bit a correct transmitter would send.
    function automatic logic ref_par(input logic [DW-1:0] d,
                                     input logic ptype);
        int  ones;
        logic odd;
        ones = $countones(d);
        odd  = (ones % 2) == 1;
        return ptype ? odd : !odd;
    endfunction

    // One serial frame; rx is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [DW-1:0] d, input logic pen,
                              input logic pbit, input logic stop_v,
                              input logic flip);
        rx = 1'b0;
        cyc(OS);
        if (flip) begin
            parity_en   = ~parity_en;
            parity_type = ~parity_type;
        end
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            cyc(OS);
        end
        if (pen) begin
            rx = pbit;
            cyc(OS);
        end
        rx = stop_v;
        cyc(OS);
    endtask

    task automatic check_frame(input string tag, input logic [DW-1:0] d,
                               input logic perr, input logic ferr);
        logic [DW+1:0] e;
        chk({tag, "_count"}, got_q.size(), 1);
        if (got_q.size() != 0) begin
            e = got_q.pop_front();
            chk({tag, "_data"}, e[DW+1:2], d);
            chk({tag, "_perr"}, e[1], perr);
            chk({tag, "_ferr"}, e[0], ferr);
        end
        got_q.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          pen, ptype, pbit, stop_v, flip;
        int            gap;

        reset       = 1'b0;
        rx          = 1'b1;
        rx_ready    = 1'b1;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        cyc(3);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun_err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        cyc(5);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        cyc(10);
        check_frame("a5", 8'hA5, 1'b0, 1'b0);

        parity_en   = 1'b1;
        parity_type = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        rx = 1'b1;
        cyc(10);
        check_frame("3c_ok", 8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        cyc(10);
        check_frame("3c_bad", 8'h3C, 1'b1, 1'b0);

        parity_en = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("81_ferr", 8'h81, 1'b0, 1'b1);
        cyc(200);
        chk("stuck_low_count", got_q.size(), 0);
        chk("stuck_low_busy", busy, 0);
        rx = 1'b1;
        cyc(20);
        chk("stuck_rel_count", got_q.size(), 0);

        rx = 1'b0;
        cyc(4);
        rx = 1'b1;
        chk("glitch_busy_hi", busy, 1);
        cyc(10);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_count", got_q.size(), 0);

        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        cyc(5);
        chk("ovr_first_ovr", overrun_err, 0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        cyc(5);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_flag", overrun_err, 1);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        chk("ovr_drain_valid", rx_valid, 0);
        chk("ovr_drain_flag", overrun_err, 0);
        check_frame("ovr_word", 8'h11, 1'b0, 1'b0);
        rx_ready = 1'b1;

        d  = 8'h55;
        rx = 1'b0;
        cyc(OS);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            cyc(OS);
        end
        reset = 1'b0;
        rx    = 1'b1;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rx_valid, 0);
        cyc(30);
        chk("midrst_count", got_q.size(), 0);
        send_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        cyc(10);
        check_frame("66", 8'h66, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            d           = DW'($urandom);
            pen         = 1'($urandom_range(0, 1));
            ptype       = 1'($urandom_range(0, 1));
            pbit        = 1'($urandom_range(0, 1));
            stop_v      = ($urandom_range(0, 5) != 0);
            flip        = 1'($urandom_range(0, 1));
            gap         = $urandom_range(2, 12);
            parity_en   = pen;
            parity_type = ptype;
            send_frame(d, pen, pbit, stop_v, flip);
            rx = 1'b1;
            cyc(gap);
            check_frame($sformatf("rnd%0d", k), d,
                        pen && (pbit != ref_par(d, ptype)), !stop_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
